// File: rtl/wslce_pkg.sv
// Shared constants and FSM encoding for the WSLCE chip sequencer.
package wslce_pkg;

    localparam int WSLCE_N    = 23;
    localparam int WSLCE_ROOT = 11;
    localparam int WSLCE_NW   = 5;
    localparam int ROOT_SQ    = (WSLCE_ROOT * WSLCE_ROOT) % WSLCE_N;

    typedef enum logic [1:0] {
        IDLE,
        BUILD_QR,
        BUILD_SEQ,
        STREAM
    } state_t;

endpackage

// File: rtl/wslce_modmul.sv
// Constant-coefficient modular multiply: y = (a * K) mod N, purely combinational.
// Zero latency, no flow control; the double-width product keeps the reduction exact.
module wslce_modmul #(
    parameter int N  = 23,
    parameter int K  = 11,
    parameter int NW = 5
) (
    input  logic [NW-1:0] a,
    output logic [NW-1:0] y
);

    logic [2*NW-1:0] prod;
    logic [2*NW-1:0] rem;

    assign prod = a * (2*NW)'(K);
    assign rem  = prod % (2*NW)'(N);
    assign y    = rem[NW-1:0];

endmodule

// File: rtl/wslce_chip_sequencer.sv
// Builds the cyclotomic slce[] sequence, forms wslce = slce ^ rotate(slce), streams chips from a phase.
// Latency start->first chip (N-1)/2+N+1 cycles (1 with cached sequence); chip/chip_idx hold while !chip_ready.
// Optional WSLCE_SEQ_CACHE_EN: reuse the last completed build and jump straight to streaming.
module wslce_chip_sequencer
    import wslce_pkg::*;
#(
    parameter int N    = WSLCE_N,
    parameter int ROOT = WSLCE_ROOT,
    parameter int NW   = WSLCE_NW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [NW-1:0] phase,
    output logic          busy,
    output logic          cfg_err,
    output logic          chip_valid,
    input  logic          chip_ready,
    output logic          chip,
    output logic [NW-1:0] chip_idx,
    output logic          period_done,
    output logic [N-1:0]  wslce_k
);

    localparam int RSQ = (ROOT * ROOT) % N;
    localparam logic [NW-1:0] N_IDX    = NW'(N);
    localparam logic [NW-1:0] IDX_LAST = NW'(N - 1);
    localparam logic [NW-1:0] QR_LAST  = NW'((N - 1) / 2 - 1);
    localparam logic [NW-1:0] ROOT_IDX = NW'(ROOT % N);
    localparam logic [NW-1:0] ONE      = NW'(1);

    state_t          state, state_nxt;
    logic            accept, cfg_err_nxt, cache_hit, hs;
    logic [NW-1:0]   p, pw, cnt, period_last;
    logic [NW-1:0]   p_mul, pw_mul, z, idx_nxt;
    logic [N-1:0]    mask, slce, slce_nxt, wslce_new;

    // p steps through odd powers of ROOT, pw through all powers.
    wslce_modmul #(.N(N), .K(RSQ),  .NW(NW)) u_mul_sq   (.a(p),  .y(p_mul));
    wslce_modmul #(.N(N), .K(ROOT), .NW(NW)) u_mul_root (.a(pw), .y(pw_mul));

    assign busy    = (state != IDLE);
    assign hs      = chip_valid & chip_ready;
    assign idx_nxt = !hs ? chip_idx : ((chip_idx == IDX_LAST) ? '0 : chip_idx + ONE);
    assign z       = (pw == IDX_LAST) ? '0 : pw + ONE;

    always_comb begin
        slce_nxt      = slce;
        slce_nxt[cnt] = mask[z];
    end

    // Final element is folded in from slce_nxt so the rotate sees the full sequence.
    assign wslce_new = slce_nxt ^ {slce_nxt[0], slce_nxt[N-1:1]};

`ifdef WSLCE_SEQ_CACHE_EN
    logic cache_vld;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cache_vld <= 1'b0;
        else if ((state == BUILD_QR || state == BUILD_SEQ) && stop)
            cache_vld <= 1'b0;
        else if (state == BUILD_SEQ && cnt == IDX_LAST)
            cache_vld <= 1'b1;
    end

    assign cache_hit = cache_vld;
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        cfg_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (phase >= N_IDX) begin
                        cfg_err_nxt = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = cache_hit ? STREAM : BUILD_QR;
                    end
                end
            end
            BUILD_QR:  if (stop) state_nxt = IDLE; else if (cnt == QR_LAST)  state_nxt = BUILD_SEQ;
            BUILD_SEQ: if (stop) state_nxt = IDLE; else if (cnt == IDX_LAST) state_nxt = STREAM;
            STREAM:    if (stop) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p           <= '0;
            pw          <= '0;
            cnt         <= '0;
            mask        <= '0;
            slce        <= '0;
            wslce_k     <= '0;
            chip        <= 1'b0;
            chip_idx    <= '0;
            chip_valid  <= 1'b0;
            period_done <= 1'b0;
            period_last <= '0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err     <= cfg_err_nxt;
            period_done <= hs && (chip_idx == period_last);
            case (state)
                IDLE: begin
                    if (accept) begin
                        chip_idx    <= phase;
                        period_last <= (phase == '0) ? IDX_LAST : phase - ONE;
                        p           <= ROOT_IDX;
                        pw          <= ONE;
                        cnt         <= '0;
                        mask        <= '0;
                    end
                end
                BUILD_QR: begin
                    if (!stop) begin
                        mask[p] <= 1'b1;
                        p       <= p_mul;
                        cnt     <= (cnt == QR_LAST) ? '0 : cnt + ONE;
                    end
                end
                BUILD_SEQ: begin
                    if (!stop) begin
                        slce <= slce_nxt;
                        pw   <= pw_mul;
                        cnt  <= cnt + ONE;
                        if (cnt == IDX_LAST)
                            wslce_k <= wslce_new;
                    end
                end
                STREAM: begin
                    if (stop) begin
                        chip_valid <= 1'b0;
                        chip_idx   <= '0;
                    end else begin
                        chip_valid <= 1'b1;
                        chip_idx   <= idx_nxt;
                        chip       <= wslce_k[idx_nxt];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
